mux_scan_sampler: RTL and testbench

MUX_SCAN_SAMPLER -- requirements
Module: mux_scan_sampler

---
 rtl/mux_scan_sampler_if.sv | 24 ++
 rtl/mux_scan_sampler.sv | 121 ++++++++++++
 tb/tb_mux_scan_sampler.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mux_scan_sampler_if.sv
// Handshake and data bundle between the scan sampler and its controller/mux.
// The sel width is one bit wider than strictly needed so it matches the downstream mux select.
interface mux_scan_sampler_if #(
  parameter int INS = 4
);
  logic                   start;
  logic                   abort;
  logic [INS-1:0]         mask;
  logic                   f_in;
  logic [$clog2(INS):0]   sel;
  logic                   busy;
  logic                   done;
  logic [INS-1:0]         snapshot;

  modport master (
    output start, abort, mask, f_in,
    input  sel, busy, done, snapshot
  );

  modport slave (
    input  start, abort, mask, f_in,
    output sel, busy, done, snapshot
  );
endinterface

// File: rtl/mux_scan_sampler.sv
// Steps an external N:1 mux through the enabled channels, holds each select for
// SETTLE cycles, and captures the mux output into a per-channel snapshot.
module mux_scan_sampler #(
  parameter int INS    = 4,
  parameter int SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  mux_scan_sampler_if.slave  bus
);

  localparam int SW = $clog2(INS) + 1;
  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [INS-1:0] mask_q, mask_d;
  logic [INS-1:0] snap_q, snap_d;
  logic           done_q, done_d;

  logic [SW-1:0]  first_idx;
  logic [SW-1:0]  next_idx;
  logic           next_vld;

  // Descending scans with overwrite leave the lowest qualifying index behind.
  always_comb begin
    first_idx = '0;
    for (int k = INS - 1; k >= 0; k--) begin
      if (bus.mask[k]) first_idx = SW'(k);
    end
  end

  always_comb begin
    next_idx = '0;
    next_vld = 1'b0;
    for (int k = INS - 1; k >= 0; k--) begin
      if (mask_q[k] && (SW'(k) > sel_q)) begin
        next_idx = SW'(k);
        next_vld = 1'b1;
      end
    end
  end

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    snap_d  = snap_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          snap_d = '0;
          if (|bus.mask) begin
            mask_d  = bus.mask;
            sel_d   = first_idx;
            cnt_d   = CW'(SETTLE);
            state_d = S_SCAN;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_SCAN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(1)) begin
          for (int k = 0; k < INS; k++) begin
            if (sel_q == SW'(k)) snap_d[k] = bus.f_in;
          end
          if (next_vld) begin
            sel_d = next_idx;
            cnt_d = CW'(SETTLE);
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch; state uses <= only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      snap_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      snap_q  <= snap_d;
      done_q  <= done_d;
    end
  end

  assign bus.sel      = sel_q;
  assign bus.busy     = (state_q == S_SCAN);
  assign bus.done     = done_q;
  assign bus.snapshot = snap_q;

endmodule

// File: tb/tb_mux_scan_sampler.sv
// Bench for mux_scan_sampler: three configurations (4/1, 4/2, 5/1) driven one at a time
// and compared cycle by cycle against an arithmetic model of the scan timeline.
module tb_mux_scan_sampler;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]      start_v, abort_v;
  logic [2:0][4:0] mask_v, w_v;
  logic [2:0]      busy_o, done_o;
  logic [2:0][3:0] sel_o;
  logic [2:0][4:0] snap_o;
  logic [2:0][3:0] exp_sel;

  int n_asserts = 0;
  int n_fail    = 0;

  mux_scan_sampler_if #(.INS(4)) if_a ();
  mux_scan_sampler_if #(.INS(4)) if_b ();
  mux_scan_sampler_if #(.INS(5)) if_c ();

  mux_scan_sampler #(.INS(4), .SETTLE(1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  mux_scan_sampler #(.INS(4), .SETTLE(2)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  mux_scan_sampler #(.INS(5), .SETTLE(1)) u_c (.clk(clk), .rst(rst), .bus(if_c));

  // The mux under each sampler: f_in = w[sel].
  assign if_a.start = start_v[0];
  assign if_a.abort = abort_v[0];
  assign if_a.mask  = mask_v[0][3:0];
  assign if_a.f_in  = 1'(w_v[0] >> if_a.sel);
  assign if_b.start = start_v[1];
  assign if_b.abort = abort_v[1];
  assign if_b.mask  = mask_v[1][3:0];
  assign if_b.f_in  = 1'(w_v[1] >> if_b.sel);
  assign if_c.start = start_v[2];
  assign if_c.abort = abort_v[2];
  assign if_c.mask  = mask_v[2];
  assign if_c.f_in  = 1'(w_v[2] >> if_c.sel);

  assign sel_o[0]  = 4'(if_a.sel);
  assign sel_o[1]  = 4'(if_b.sel);
  assign sel_o[2]  = if_c.sel;
  assign busy_o    = {if_c.busy, if_b.busy, if_a.busy};
  assign done_o    = {if_c.done, if_b.done, if_a.done};
  assign snap_o[0] = 5'(if_a.snapshot);
  assign snap_o[1] = 5'(if_b.snapshot);
  assign snap_o[2] = if_c.snapshot;

  function automatic int ins_of(input int c);
    return (c == 2) ? 5 : 4;
  endfunction

  function automatic int settle_of(input int c);
    return (c == 1) ? 2 : 1;
  endfunction

  function automatic logic [4:0] ins_mask(input int c);
    return (5'd1 << ins_of(c)) - 5'd1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input int c, input string when, input logic [3:0] esel,
                           input logic ebusy, input logic edone, input logic [4:0] esnap);
    check($sformatf("c%0d %s sel", c, when),  32'(sel_o[c]),  32'(esel));
    check($sformatf("c%0d %s busy", c, when), 32'(busy_o[c]), 32'(ebusy));
    check($sformatf("c%0d %s done", c, when), 32'(done_o[c]), 32'(edone));
    check($sformatf("c%0d %s snap", c, when), 32'(snap_o[c]), 32'(esnap));
  endtask

  // Model: enabled channels in ascending order, each owning SETTLE cycles; channel j is
  // captured on edge (j+1)*SETTLE after accept; abort on edge A keeps captures up to A-1.
  task automatic run_scan(input int c, input logic [4:0] m, input logic [4:0] w, input int abort_at);
    int ch[$];
    int s, n, term, tc;
    bit aborted;
    logic [4:0] cap;
    logic [3:0] esel;
    logic       ebusy, edone;
    s = settle_of(c);
    for (int k = 0; k < ins_of(c); k++) if (m[k]) ch.push_back(k);
    n       = ch.size();
    aborted = (n > 0) && (abort_at > 0) && (abort_at <= n * s);
    term    = (n == 0) ? 0 : (aborted ? abort_at : n * s);
    esel    = exp_sel[c];
    @(negedge clk);
    w_v[c]     = w;
    mask_v[c]  = m;
    start_v[c] = 1'b1;
    abort_v[c] = 1'b0;
    for (int t = 0; t <= term + 1; t++) begin
      if (t > 0) begin
        @(negedge clk);
        mask_v[c]  = 5'($urandom) & ins_mask(c);
        start_v[c] = (t <= term) ? 1'($urandom) : 1'b0;
        abort_v[c] = (t == term + 1) || (aborted && t == abort_at);
      end
      @(posedge clk);
      #1;
      if (aborted && t >= term) tc = term - 1;
      else tc = (t < n * s) ? t : n * s;
      cap = '0;
      for (int j = 0; j < n; j++) begin
        if ((j + 1) * s <= tc) cap |= w & (5'd1 << ch[j]);
      end
      if (n == 0) begin
        ebusy = 1'b0;
        edone = (t == 0);
      end else if (t < term) begin
        esel  = 4'(ch[t / s]);
        ebusy = 1'b1;
        edone = 1'b0;
      end else begin
        esel  = aborted ? 4'(ch[(term - 1) / s]) : 4'(ch[n - 1]);
        ebusy = 1'b0;
        edone = (t == term) && !aborted;
      end
      check_all(c, $sformatf("m%0h t%0d", m, t), esel, ebusy, edone, cap);
    end
    exp_sel[c] = esel;
    @(negedge clk);
    start_v[c] = 1'b0;
    abort_v[c] = 1'b0;
  endtask

  initial begin
    int c, ab;
    logic [4:0] m, w;
    start_v = '0;
    abort_v = '0;
    mask_v  = '0;
    w_v     = '0;
    exp_sel = '0;
    rst     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check_all(k, "reset", 4'd0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    rst = 1'b0;

    run_scan(0, 5'b01111, 5'b01010, 0);     // full scan, SETTLE=1
    run_scan(1, 5'b00101, 5'b01111, 0);     // sparse mask, SETTLE=2
    run_scan(0, 5'b00000, 5'b01111, 0);     // empty mask: done on accept, sel held
    run_scan(0, 5'b01111, 5'b01111, 3);     // abort while sel=2
    run_scan(2, 5'b10000, 5'b10000, 0);     // non-power-of-two width, top channel only
    run_scan(1, 5'b01111, 5'b00110, 8);     // abort collides with completion

    for (int it = 0; it < 30; it++) begin
      c  = it % 3;
      m  = 5'($urandom) & ins_mask(c);
      w  = 5'($urandom);
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(8, 1)) : 0;
      run_scan(c, m, w, ab);
    end

    // Reset mid-scan, with start also high, discards the scan.
    @(negedge clk);
    w_v[0]     = 5'b01111;
    mask_v[0]  = 5'b01111;
    start_v[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all(0, "midrst", 4'd0, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    rst        = 1'b0;
    start_v[0] = 1'b0;
    @(posedge clk);
    #1;
    check_all(0, "postrst", 4'd0, 1'b0, 1'b0, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
